// File: rtl/alu_pkg.sv
// Shared op-code encodings and FSM state type for the ALU arbiter slice.
package alu_pkg;

    localparam logic [3:0] ALU_ADD    = 4'h0;
    localparam logic [3:0] ALU_SUB    = 4'h1;
    localparam logic [3:0] ALU_SHL    = 4'h2;
    localparam logic [3:0] ALU_SLTU   = 4'h3;
    localparam logic [3:0] ALU_XOR    = 4'h4;
    localparam logic [3:0] ALU_SHR    = 4'h5;
    localparam logic [3:0] ALU_SRA    = 4'h6;
    localparam logic [3:0] ALU_OR     = 4'h7;
    localparam logic [3:0] ALU_AND    = 4'h8;
    localparam logic [3:0] ALU_EQ     = 4'h9;
    localparam logic [3:0] ALU_OP_MAX = 4'h9;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU datapath shared by both requesters of alu_arbiter.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned OP_W   = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    logic [31:0] op_ext;
    logic [5:0]  sh;

    always_comb begin
        op_ext = 32'(op);
        sh     = b[5:0];
        result = '0;
        err    = 1'b0;
        // Codes beyond the defined set report an error with a zero result.
        if (op_ext > 32'(ALU_OP_MAX)) begin
            err = 1'b1;
        end else begin
            case (op_ext[3:0])
                ALU_ADD:  result = a + b;
                ALU_SUB:  result = a - b;
                ALU_SHL:  result = a << sh;
                ALU_SLTU: result = DATA_W'(a < b);
                ALU_XOR:  result = a ^ b;
                ALU_SHR:  result = a >> sh;
                ALU_SRA:  result = $unsigned($signed(a) >>> sh);
                ALU_OR:   result = a | b;
                ALU_AND:  result = a & b;
                ALU_EQ:   result = DATA_W'(a == b);
                default:  result = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: IDLE -> EXEC -> HOLD per operation.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise requester 0 has fixed priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    output logic              busy
);

    state_t            state;
    logic              owner;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;
    logic              gnt1;
    logic              accept;
    logic              owner_ready;
    logic [DATA_W-1:0] alu_result;
    logic              alu_err;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic              last_grant;
`endif

    always_comb begin
        gnt1 = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (req0_valid && req1_valid)
            gnt1 = ~last_grant;
        else
            gnt1 = req1_valid;
`else
        gnt1 = req1_valid && !req0_valid;
`endif
    end

    // rst_n gates the handshake so ready drops the instant reset asserts.
    assign accept      = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready  = accept && !gnt1;
    assign req1_ready  = accept && gnt1;
    assign owner_ready = owner ? rsp1_ready : rsp0_ready;

    alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .err    (alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= gnt1;
                        a_q   <= gnt1 ? req1_a  : req0_a;
                        b_q   <= gnt1 ? req1_b  : req0_b;
                        op_q  <= gnt1 ? req1_op : req0_op;
                        busy  <= 1'b1;
                        state <= EXEC;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        last_grant <= gnt1;
`endif
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_err    <= alu_err;
                    rsp0_valid <= ~owner;
                    rsp1_valid <= owner;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (owner_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus randomized traffic against a behavioural model.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [63:0] rsp_result;
    logic        rsp_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int m_last = 1;

    alu_arbiter #(
        .DATA_W (64),
        .OP_W   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s/%s: observed %h expected %h", tag, what, obs, exp);
        end
    endtask

    // Reference ALU from the operation table, using plain arithmetic.
    function automatic void model_alu(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                                      output logic [63:0] r, output logic e);
        int unsigned s;
        logic [63:0] ones;
        s    = b % 64;
        ones = '1;
        r    = '0;
        e    = 1'b0;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a << s;
            3: r = (a < b) ? 64'd1 : 64'd0;
            4: r = a ^ b;
            5: r = a >> s;
            6: r = (a >> s) | (a[63] ? ~(ones >> s) : 64'd0);
            7: r = a | b;
            8: r = a & b;
            9: r = (a == b) ? 64'd1 : 64'd0;
            default: begin r = '0; e = 1'b1; end
        endcase
    endfunction

    function automatic int model_grant(input logic v0, input logic v1);
        if (!v0 && !v1) return -1;
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        return (m_last == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Called just after a rising edge while IDLE with requests already driven.
    task automatic serve(input int hold, input string tag);
        int g;
        logic [63:0] er;
        logic ee;
        #1;
        g = model_grant(req0_valid, req1_valid);
        chk(tag, "rdy0", req0_ready, g == 0);
        chk(tag, "rdy1", req1_ready, g == 1);
        if (g < 0) return;
        if (g == 0) model_alu(req0_a, req0_b, req0_op, er, ee);
        else        model_alu(req1_a, req1_b, req1_op, er, ee);
        m_last = g;
        @(posedge clk); #1;
        if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        chk(tag, "exec_busy", busy, 1'b1);
        chk(tag, "exec_v0", rsp0_valid, 1'b0);
        chk(tag, "exec_v1", rsp1_valid, 1'b0);
        chk(tag, "exec_rdy", {req0_ready, req1_ready}, 2'b00);
        @(posedge clk); #1;
        for (int k = 0; k <= hold; k++) begin
            chk(tag, "hold_v0", rsp0_valid, g == 0);
            chk(tag, "hold_v1", rsp1_valid, g == 1);
            chk(tag, "result", rsp_result, er);
            chk(tag, "err", rsp_err, ee);
            chk(tag, "hold_busy", busy, 1'b1);
            chk(tag, "hold_rdy", {req0_ready, req1_ready}, 2'b00);
            if (g == 0) begin
                rsp0_ready = (k == hold);
                rsp1_ready = 1'($urandom_range(0, 1));
            end else begin
                rsp1_ready = (k == hold);
                rsp0_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk(tag, "idle_busy", busy, 1'b0);
        chk(tag, "idle_v", {rsp0_valid, rsp1_valid}, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        #3;
        chk("reset", "busy", busy, 1'b0);
        chk("reset", "rsp_v", {rsp0_valid, rsp1_valid}, 2'b00);
        chk("reset", "rdy", {req0_ready, req1_ready}, 2'b00);
        chk("reset", "result", rsp_result, 64'd0);
        chk("reset", "err", rsp_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_clk", "rdy", {req0_ready, req1_ready}, 2'b00);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        m_last = 1;
        @(posedge clk); #1;

        // No valid -> no ready; a valid withdrawn before the edge is not accepted.
        chk("novalid", "rdy", {req0_ready, req1_ready}, 2'b00);
        req1_valid = 1'b1; #1;
        chk("withdraw", "rdy1", req1_ready, 1'b1);
        req1_valid = 1'b0; #1;
        chk("withdraw", "rdy1_low", req1_ready, 1'b0);
        @(posedge clk); #1;
        chk("withdraw", "busy", busy, 1'b0);

        req0_a = 64'd5; req0_b = 64'd3; req0_op = 4'd0; req0_valid = 1'b1;
        serve(0, "add");

        req0_a = 64'd3; req0_b = 64'd5; req0_op = 4'd1;
        req1_a = 64'd3; req1_b = 64'd5; req1_op = 4'd1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        serve(0, "both1");
        req0_valid = 1'b1;
        serve(0, "both2");
        if (req0_valid || req1_valid) serve(0, "both3");

        req1_a = 64'h1234; req1_b = 64'h55; req1_op = 4'hC; req1_valid = 1'b1;
        serve(0, "badop");

        req0_a = 64'hDEAD_BEEF_0000_0001; req0_b = 64'h10; req0_op = 4'd7; req0_valid = 1'b1;
        serve(10, "stall");
        req1_valid = 1'b1; req1_op = 4'd9; req1_a = 64'h77; req1_b = 64'h77;
        req0_valid = 1'b1;
        serve(10, "stall_both");
        if (req0_valid || req1_valid) serve(0, "stall_drain");

        req0_a = 64'h8000_0000_0000_0000; req0_b = 64'd4; req0_op = 4'd6; req0_valid = 1'b1;
        serve(0, "sra");

        // Reset while holding a response.
        req0_a = 64'd1; req0_b = 64'd2; req0_op = 4'd0; req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_hold", "pre_v0", rsp0_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_hold", "v0", rsp0_valid, 1'b0);
        chk("rst_hold", "busy", busy, 1'b0);
        chk("rst_hold", "result", rsp_result, 64'd0);
        req1_valid = 1'b1; #1;
        chk("rst_hold", "rdy1", req1_ready, 1'b0);
        req1_valid = 1'b0;
        rst_n = 1'b1;
        m_last = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rst_after", "rsp_v", {rsp0_valid, rsp1_valid}, 2'b00);
            chk("rst_after", "busy", busy, 1'b0);
        end

        for (int i = 0; i < 40; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            if (!req0_valid && !req1_valid) req0_valid = 1'b1;
            req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
            req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
            if (i % 3 == 0) req0_b = 64'($urandom_range(0, 70));
            if (i % 4 == 0) req1_a = req1_b;
            req0_op = 4'($urandom_range(0, 15));
            req1_op = 4'($urandom_range(0, 15));
            serve($urandom_range(0, 2), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
